// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port among NUM_REQ writeback sources with a one-cycle registered output.
// Build macro RR_ARB_EN selects round-robin arbitration; when it is undefined, the lowest valid index always wins.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int STALL_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         regw_address,
  output logic [DATA_W-1:0]         write_data,
  output logic [STALL_W-1:0]        stall_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] grant_s;
  logic               found_s;
  logic [PTR_W-1:0]   win_idx_s;
  logic [ADDR_W-1:0]  win_addr_s;
  logic [DATA_W-1:0]  win_data_s;
  logic               xfer_s;
  logic               stall_hit_s;

  logic               regwrite_q, regwrite_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [STALL_W-1:0] stall_q, stall_d;

`ifdef RR_ARB_EN
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_s = '0;
    found_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found_s && req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        grant_s[(int'(rr_ptr_q) + k) % NUM_REQ] = 1'b1;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer advances past the winner; holds when nothing transfers.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer_s) begin
      if (win_idx_s == PTR_W'(NUM_REQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = win_idx_s + PTR_W'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  // Fixed priority: the lowest valid index wins.
  always_comb begin
    grant_s = '0;
    found_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found_s && req_valid[k]) begin
        grant_s[k] = 1'b1;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end
`endif

  // The grant is gated off during reset so nothing transfers while rst is high.
  assign req_ready = rst ? '0 : grant_s;
  assign xfer_s    = |req_ready;

  // Encode the one-hot grant and select the winning payload.
  always_comb begin
    win_idx_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_idx_s = win_idx_s | (grant_s[i] ? PTR_W'(i) : PTR_W'(0));
    end
    win_addr_s = req_addr[int'(win_idx_s)*ADDR_W +: ADDR_W];
    win_data_s = req_data[int'(win_idx_s)*DATA_W +: DATA_W];
  end

  assign stall_hit_s = |(req_valid & ~req_ready);

  // Output stage next state: writes to $zero are consumed but not enabled.
  always_comb begin
    regwrite_d = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    stall_d    = stall_q;
    if (xfer_s) begin
      regwrite_d = (win_addr_s != '0);
      addr_d     = win_addr_s;
      data_d     = win_data_s;
    end else begin
      regwrite_d = 1'b0;
    end
    if (stall_hit_s && (stall_q != {STALL_W{1'b1}})) begin
      stall_d = stall_q + STALL_W'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  // Output and stall counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      stall_q    <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      stall_q    <= stall_d;
    end
  end

  assign RegWrite     = regwrite_q;
  assign regw_address = addr_q;
  assign write_data   = data_q;
  assign stall_cnt    = stall_q;

endmodule
